instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Program-counter sequencer that drives the instruction memory's `pc_address` input and captures the returned instruction byte. It presents that byte to the decode/execute stage over a valid/ready handshake and stops at the HALT opcode. It accepts redirects (jumps) from execute and counts delivered instructions. It sits between the instruction memory, which is combinational on address, and the decoder.

## Interface
Parameters:
- `ADDR_WIDTH`, 8, width of the program counter and memory address.
- `DATA_WIDTH`, 8, instruction width.
- `PC_STEP`, 2, PC increment per fetch (byte-pair aligned program).
- `RESET_PC`, 8'h00, PC value after reset.
- `HALT_OPCODE`, 8'hFF, opcode that terminates fetching.

Ports:
- `clk`  input  1  single clock; all state updates on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  begin fetching from `RESET_PC`; sampled in IDLE only.
- `instr_in`  input  DATA_WIDTH  instruction returned by memory for the current `pc_address` (same cycle).
- `pc_address`  output  ADDR_WIDTH  registered address to instruction memory.
- `instr`  output  DATA_WIDTH  registered instruction to decoder.
- `instr_valid`  output  1  `instr` holds an undelivered instruction.
- `instr_ready`  input  1  decoder accepts `instr` this cycle.
- `jump_en`  input  1  redirect request from execute.
- `jump_target`  input  ADDR_WIDTH  redirect address. Bit 0 is forced to 0.
- `busy`  output  1  high in FETCH.
- `halted`  output  1  high in HALTED.
- `fetch_count`  output  8  delivered-instruction count. Saturates at 255.

## Operation
- Reset values:
  - `pc_address`=RESET_PC
  - `instr`=0
  - `instr_valid`=0
  - `busy`=0
  - `halted`=0
  - `fetch_count`=0
  - state=IDLE
- IDLE:
  - `start`=1 -> FETCH, with `pc_address`=RESET_PC.
  - `jump_en` and `instr_ready` are ignored.
- FETCH:
  - Define capture = `!instr_valid || instr_ready`.
  - On capture: `instr`<=`instr_in`, `instr_valid`<=1, `pc_address`<=`pc_address`+PC_STEP (mod 2^ADDR_WIDTH).
  - Without capture (`instr_valid` && !`instr_ready`): hold `instr`, `instr_valid`, and `pc_address` (stall).
  - On capture where `instr_in`==HALT_OPCODE: HALT is loaded and presented, `pc_address` is NOT incremented, and the state goes to HALTED.
- Jump (FETCH only) has priority over capture and stall:
  - `pc_address`<={`jump_target`[ADDR_WIDTH-1:1],1'b0}.
  - `instr_valid`<=0; the held instruction is squashed and not counted.
  - The state stays in FETCH.
- HALTED:
  - `pc_address` frozen at the HALT address.
  - The HALT instruction stays valid until accepted, then `instr_valid`<=0.
  - `start` and `jump_en` are ignored; only `reset` exits.
- `fetch_count` increments on each cycle with `instr_valid && instr_ready && !jump_en`, and holds at 255.
- Wrap-around: at `pc_address`=8'hFE with PC_STEP=2, the next address is 8'h00. No error is flagged.

## Timing
- Fetch latency: `start` sampled at edge N, so `pc_address`=RESET_PC during cycle N+1. `instr`/`instr_valid` show that word after edge N+1.
- Throughput: one instruction per cycle while `instr_ready`=1.
- Redirect: `jump_en` at edge N puts the target on `pc_address` in cycle N+1. The first target instruction is valid after edge N+1, a one-bubble penalty.
- `halted` rises at the same edge that loads HALT into `instr`.
- Reset mid-operation: everything returns to reset values at that edge, including a pending valid instruction, which is dropped.
- Simultaneous `jump_en` and `instr_ready`: the jump wins, and the held instruction is neither delivered nor counted.

## Configuration
- Macro `FETCH_SKIP_NOP_EN`.
- Defined: on a capture where `instr_in`==8'h00 (NOP), `pc_address` advances but `instr_valid`<=0. NOPs never reach the decoder and are never counted.
- Undefined: NOPs are delivered and counted like any other instruction.

## Test plan
The memory model returns 00,D3,50,D1,51,10,FF at addresses 0,2,4,6,8,10,12, and 00 elsewhere.

- Reset then `start`, `instr_ready`=1 always:
  - Expect `instr` sequence 00,D3,50,D1,51,10,FF on consecutive cycles.
  - Then `halted`=1, `pc_address`=12, `fetch_count`=7.
  - With `FETCH_SKIP_NOP_EN`: same sequence minus 00, and `fetch_count`=6.
- Stall: drop `instr_ready` for 3 cycles while `instr`=50.
  - `instr`=50, `instr_valid`=1, and `pc_address`=6 all hold.
  - After release the next instruction is D1, with none lost or duplicated.
- Jump: assert `jump_en`, `jump_target`=8'h0B while `instr`=D3 is valid and `instr_ready`=1.
  - D3 is squashed and not counted.
  - `pc_address`=10 in the next cycle, then `instr`=10, then FF and halted.
- Wrap: jump to 8'hFE.
  - `instr`=00 from FE is followed by `pc_address`=00.
  - The program then replays from address 0.
- Reset in FETCH mid-stall: all outputs return to reset values in one cycle, and `start` is required to resume.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// Fetch bus: instruction-memory address/data plus the decoder-side
// valid/ready handshake and the redirect request coming back from execute.
// The master modport is the fetch unit; the slave modport is the
// memory/decoder/execute environment around it.
interface instruction_fetch_unit_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] pc_address;
  logic [DATA_WIDTH-1:0] instr_in;
  logic [DATA_WIDTH-1:0] instr;
  logic                  instr_valid;
  logic                  instr_ready;
  logic                  jump_en;
  logic [ADDR_WIDTH-1:0] jump_target;

  modport master (
    output pc_address, instr, instr_valid,
    input  instr_in, instr_ready, jump_en, jump_target
  );

  modport slave (
    input  pc_address, instr, instr_valid,
    output instr_in, instr_ready, jump_en, jump_target
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Program-counter sequencer. Drives a combinational instruction memory,
// registers the returned byte for the decoder behind a valid/ready
// handshake, follows redirects from execute and stops on the HALT opcode.
// Optional build macro FETCH_SKIP_NOP_EN: NOP (8'h00) bytes are stepped
// over without ever being presented or counted.
module instruction_fetch_unit #(
  parameter int                   ADDR_WIDTH  = 8,
  parameter int                   DATA_WIDTH  = 8,
  parameter int                   PC_STEP     = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = 8'h00,
  parameter logic [DATA_WIDTH-1:0] HALT_OPCODE = 8'hFF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  instruction_fetch_unit_if.master     bus,
  output logic                         busy,
  output logic                         halted,
  output logic [7:0]                   fetch_count
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HALTED
  } state_t;

  state_t                state;
  logic                  capture;
  logic                  deliver;
  logic                  is_halt;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic [ADDR_WIDTH-1:0] jump_pc;
`ifdef FETCH_SKIP_NOP_EN
  logic                  is_nop;
`endif

  // Handshake qualifiers and next-address candidates for this cycle.
  // NOTE: every always_comb output is assigned unconditionally, so no latch can form.
  always_comb begin
    capture = !bus.instr_valid || bus.instr_ready;
    // A redirect squashes the held word in FETCH; HALTED ignores jump_en.
    deliver = bus.instr_valid && bus.instr_ready && !((state == FETCH) && bus.jump_en);
    is_halt = (bus.instr_in == HALT_OPCODE);
    pc_next = bus.pc_address + ADDR_WIDTH'(PC_STEP);
    jump_pc = bus.jump_target & ~ADDR_WIDTH'(1);
`ifdef FETCH_SKIP_NOP_EN
    is_nop  = (bus.instr_in == '0);
`endif
  end

  // Fetch FSM with registered outputs and the delivered-instruction counter.
  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      bus.pc_address  <= RESET_PC;
      bus.instr       <= '0;
      bus.instr_valid <= 1'b0;
      busy            <= 1'b0;
      halted          <= 1'b0;
      fetch_count     <= '0;
    end else begin
      if (deliver && (fetch_count != 8'hFF)) begin
        fetch_count <= fetch_count + 8'd1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state          <= FETCH;
            busy           <= 1'b1;
            bus.pc_address <= RESET_PC;
          end
        end

        FETCH: begin
          if (bus.jump_en) begin
            bus.pc_address  <= jump_pc;
            bus.instr_valid <= 1'b0;
          end else if (capture) begin
            if (is_halt) begin
              // HALT is presented but the PC stays on its address.
              bus.instr       <= bus.instr_in;
              bus.instr_valid <= 1'b1;
              state           <= HALTED;
              busy            <= 1'b0;
              halted          <= 1'b1;
`ifdef FETCH_SKIP_NOP_EN
            end else if (is_nop) begin
              bus.instr_valid <= 1'b0;
              bus.pc_address  <= pc_next;
`endif
            end else begin
              bus.instr       <= bus.instr_in;
              bus.instr_valid <= 1'b1;
              bus.pc_address  <= pc_next;
            end
          end
        end

        HALTED: begin
          if (bus.instr_valid && bus.instr_ready) begin
            bus.instr_valid <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed vector table, delivered-stream
// sequence, then randomized traffic against a cycle-level behavioural model.
module tb_instruction_fetch_unit;

  logic       clk;
  logic       reset;
  logic       start;
  logic       busy;
  logic       halted;
  logic [7:0] fetch_count;
  logic [7:0] mem [256];

  int n_vec;
  int n_err;

  instruction_fetch_unit_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

  instruction_fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .bus         (bus),
    .busy        (busy),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  assign bus.instr_in = mem[bus.pc_address];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst, st, rdy, jmp;
    logic [7:0] tgt;
    logic [7:0] e_instr;
    logic       e_valid;
    logic [7:0] e_pc;
    logic       e_busy, e_halt;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic st, logic rdy, logic jmp, logic [7:0] tgt,
                              logic [7:0] ei, logic ev, logic [7:0] ep,
                              logic eb, logic eh, logic [7:0] ec);
    vec_t v;
    v.rst = rst; v.st = st; v.rdy = rdy; v.jmp = jmp; v.tgt = tgt;
    v.e_instr = ei; v.e_valid = ev; v.e_pc = ep; v.e_busy = eb; v.e_halt = eh; v.e_cnt = ec;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Inputs are driven on the falling edge, outputs sampled on the next falling edge.
  task automatic drive(input logic r, input logic s, input logic rd, input logic j, input logic [7:0] jt);
    reset           = r;
    start           = s;
    bus.instr_ready = rd;
    bus.jump_en     = j;
    bus.jump_target = jt;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- behavioural reference model ----------------
  logic [7:0] m_pc, m_instr, m_cnt;
  logic       m_valid, m_busy, m_halt;
`ifdef FETCH_SKIP_NOP_EN
  localparam bit SKIP_NOP = 1'b1;
`else
  localparam bit SKIP_NOP = 1'b0;
`endif

  task automatic model_step(input logic r, input logic s, input logic rd, input logic j, input logic [7:0] jt);
    logic [7:0] word;
    word = mem[m_pc];
    if (r) begin
      m_pc = 8'h00; m_instr = 8'h00; m_valid = 0; m_busy = 0; m_halt = 0; m_cnt = 0;
    end else if (m_halt) begin
      if (m_valid && rd) begin
        if (m_cnt < 255) m_cnt++;
        m_valid = 0;
      end
    end else if (m_busy) begin
      if (m_valid && rd && !j && m_cnt < 255) m_cnt++;
      if (j) begin
        m_pc = {jt[7:1], 1'b0};
        m_valid = 0;
      end else if (!m_valid || rd) begin
        if (word == 8'hFF) begin
          m_instr = word; m_valid = 1; m_halt = 1; m_busy = 0;
        end else if (SKIP_NOP && word == 8'h00) begin
          m_valid = 0; m_pc = m_pc + 8'd2;
        end else begin
          m_instr = word; m_valid = 1; m_pc = m_pc + 8'd2;
        end
      end
    end else if (s) begin
      m_busy = 1;
      m_pc = 8'h00;
    end
  endtask

  task automatic model_cycle(input logic r, input logic s, input logic rd, input logic j, input logic [7:0] jt, input int idx);
    drive(r, s, rd, j, jt);
    model_step(r, s, rd, j, jt);
    tick();
    check($sformatf("rnd%0d pc", idx), bus.pc_address, m_pc);
    check($sformatf("rnd%0d valid", idx), bus.instr_valid, m_valid);
    check($sformatf("rnd%0d busy", idx), busy, m_busy);
    check($sformatf("rnd%0d halted", idx), halted, m_halt);
    check($sformatf("rnd%0d count", idx), fetch_count, m_cnt);
    if (m_valid) check($sformatf("rnd%0d instr", idx), bus.instr, m_instr);
  endtask

  task automatic load_program();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h00; mem[2] = 8'hD3; mem[4] = 8'h50; mem[6] = 8'hD1;
    mem[8] = 8'h51; mem[10] = 8'h10; mem[12] = 8'hFF;
  endtask

  logic [7:0] got[$];
  logic [7:0] want[$];

  initial begin
    n_vec = 0;
    n_err = 0;
    load_program();
    @(negedge clk);
    drive(1, 0, 0, 0, 8'h00);
    tick();
    tick();

    // Reset state
    check("reset pc", bus.pc_address, 8'h00);
    check("reset instr", bus.instr, 8'h00);
    check("reset valid", bus.instr_valid, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset halted", halted, 1'b0);
    check("reset count", fetch_count, 8'h00);

`ifndef FETCH_SKIP_NOP_EN
    // Directed table: full run with stall, halt, jump, mid-stall reset, wrap.
    tbl.push_back(mk(0,1,1,0,8'h00, 8'h00,0,8'h00,1,0,0));
    tbl.push_back(mk(0,0,1,0,8'h00, 8'h00,1,8'h02,1,0,0));
    tbl.push_back(mk(0,0,1,0,8'h00, 8'hD3,1,8'h04,1,0,1));
    tbl.push_back(mk(0,0,1,0,8'h00, 8'h50,1,8'h06,1,0,2));
    tbl.push_back(mk(0,0,0,0,8'h00, 8'h50,1,8'h06,1,0,2));
    tbl.push_back(mk(0,0,0,0,8'h00, 8'h50,1,8'h06,1,0,2));
    tbl.push_back(mk(0,0,0,0,8'h00, 8'h50,1,8'h06,1,0,2));
    tbl.push_back(mk(0,0,1,0,8'h00, 8'hD1,1,8'h08,1,0,3));
    tbl.push_back(mk(0,0,1,0,8'h00, 8'h51,1,8'h0A,1,0,4));
    tbl.push_back(mk(0,0,1,0,8'h00, 8'h10,1,8'h0C,1,0,5));
    tbl.push_back(mk(0,0,1,0,8'h00, 8'hFF,1,8'h0C,0,1,6));
    tbl.push_back(mk(0,0,1,0,8'h00, 8'hFF,0,8'h0C,0,1,7));
    tbl.push_back(mk(0,1,1,1,8'h02, 8'hFF,0,8'h0C,0,1,7));
    tbl.push_back(mk(1,0,0,0,8'h00, 8'h00,0,8'h00,0,0,0));
    tbl.push_back(mk(0,1,1,0,8'h00, 8'h00,0,8'h00,1,0,0));
    tbl.push_back(mk(0,0,1,0,8'h00, 8'h00,1,8'h02,1,0,0));
    tbl.push_back(mk(0,0,1,0,8'h00, 8'hD3,1,8'h04,1,0,1));
    tbl.push_back(mk(0,0,1,1,8'h0B, 8'hD3,0,8'h0A,1,0,1));
    tbl.push_back(mk(0,0,1,0,8'h00, 8'h10,1,8'h0C,1,0,1));
    tbl.push_back(mk(0,0,1,0,8'h00, 8'hFF,1,8'h0C,0,1,2));
    tbl.push_back(mk(0,0,1,0,8'h00, 8'hFF,0,8'h0C,0,1,3));
    tbl.push_back(mk(1,0,0,0,8'h00, 8'h00,0,8'h00,0,0,0));
    tbl.push_back(mk(0,1,1,0,8'h00, 8'h00,0,8'h00,1,0,0));
    tbl.push_back(mk(0,0,0,0,8'h00, 8'h00,1,8'h02,1,0,0));
    tbl.push_back(mk(0,0,0,0,8'h00, 8'h00,1,8'h02,1,0,0));
    tbl.push_back(mk(1,0,0,0,8'h00, 8'h00,0,8'h00,0,0,0));
    tbl.push_back(mk(0,0,1,0,8'h00, 8'h00,0,8'h00,0,0,0));
    tbl.push_back(mk(0,1,1,0,8'h00, 8'h00,0,8'h00,1,0,0));
    tbl.push_back(mk(0,0,1,0,8'h00, 8'h00,1,8'h02,1,0,0));
    tbl.push_back(mk(0,0,1,1,8'hFE, 8'h00,0,8'hFE,1,0,0));
    tbl.push_back(mk(0,0,1,0,8'h00, 8'h00,1,8'h00,1,0,0));
    tbl.push_back(mk(0,0,1,0,8'h00, 8'h00,1,8'h02,1,0,1));
    tbl.push_back(mk(0,0,1,0,8'h00, 8'hD3,1,8'h04,1,0,2));
    tbl.push_back(mk(0,0,1,0,8'h00, 8'h50,1,8'h06,1,0,3));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].st, tbl[i].rdy, tbl[i].jmp, tbl[i].tgt);
      tick();
      check($sformatf("vec%0d pc", i), bus.pc_address, tbl[i].e_pc);
      check($sformatf("vec%0d valid", i), bus.instr_valid, tbl[i].e_valid);
      check($sformatf("vec%0d busy", i), busy, tbl[i].e_busy);
      check($sformatf("vec%0d halted", i), halted, tbl[i].e_halt);
      check($sformatf("vec%0d count", i), fetch_count, tbl[i].e_cnt);
      if (tbl[i].e_valid || (!tbl[i].e_busy && !tbl[i].e_halt))
        check($sformatf("vec%0d instr", i), bus.instr, tbl[i].e_instr);
    end
`endif

    // Delivered-stream sequence: ready held high, collect every accepted word.
    drive(1, 0, 0, 0, 8'h00);
    tick();
    drive(0, 1, 1, 0, 8'h00);
    tick();
    drive(0, 0, 1, 0, 8'h00);
    for (int c = 0; c < 14; c++) begin
      if (bus.instr_valid) got.push_back(bus.instr);
      tick();
    end
    if (!SKIP_NOP) want.push_back(8'h00);
    want.push_back(8'hD3); want.push_back(8'h50); want.push_back(8'hD1);
    want.push_back(8'h51); want.push_back(8'h10); want.push_back(8'hFF);
    check("stream length", got.size(), want.size());
    foreach (want[k]) begin
      if (k < got.size()) check($sformatf("stream word%0d", k), got[k], want[k]);
    end
    check("stream halted", halted, 1'b1);
    check("stream pc", bus.pc_address, 8'h0C);
    check("stream count", fetch_count, SKIP_NOP ? 8'd6 : 8'd7);
    check("stream valid drop", bus.instr_valid, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 256; i++) begin
      case ($urandom_range(0, 15))
        0:       mem[i] = 8'hFF;
        1, 2, 3: mem[i] = 8'h00;
        default: mem[i] = 8'($urandom);
      endcase
    end
    model_cycle(1, 0, 0, 0, 8'h00, 0);
    for (int i = 1; i < 2000; i++) begin
      logic r, s, rd, j;
      r  = ($urandom_range(0, 39) == 0);
      s  = ($urandom_range(0, 1) == 0);
      rd = ($urandom_range(0, 9) < 7);
      j  = ($urandom_range(0, 9) == 0) && !m_halt;
      model_cycle(r, s, rd, j, 8'($urandom), i);
    end

    // Counter saturation: a program with no HALT and no NOP, ready always high.
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(1, 254));
    model_cycle(1, 0, 1, 0, 8'h00, 5000);
    model_cycle(0, 1, 1, 0, 8'h00, 5001);
    for (int i = 0; i < 300; i++) model_cycle(0, 0, 1, 0, 8'h00, 5002 + i);
    check("saturated count", fetch_count, 8'd255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
